// File: rtl/clock_enable_pkg.sv
// Shared constants, channel configuration type and release-counter sizing helpers
// for the clock-enable generator.
package clock_enable_pkg;

    localparam logic MODE_INT  = 1'b0;
    localparam logic MODE_FRAC = 1'b1;

    // Widest word a channel can be built with; narrower channels zero-extend into it.
    localparam int unsigned CE_WORD_MAX_W = 32;

    typedef struct packed {
        logic                     mode;
        logic [CE_WORD_MAX_W-1:0] word;
    } ce_cfg_t;

    function automatic int unsigned rel_cnt_sat(input int unsigned delay,
                                                input int unsigned num_ch,
                                                input int unsigned gap);
        return delay + (num_ch - 1) * gap;
    endfunction

    function automatic int unsigned rel_cnt_width(input int unsigned sat);
        return (sat < 2) ? 1 : $clog2(sat + 1);
    endfunction

endpackage

// File: rtl/ce_channel.sv
// One enable channel: integer divider or fractional phase accumulator, with a
// shadow configuration that is swapped in on a wrap/carry or while idle.
module ce_channel
    import clock_enable_pkg::*;
#(
    parameter int unsigned              ACC_W        = 16,
    parameter logic [CE_WORD_MAX_W-1:0] DEFAULT_WORD = 27
) (
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_rel_n,
    input  logic    i_run,
    input  logic    i_cfg_we,
    input  ce_cfg_t i_cfg,
    output logic    o_en,
    output logic    o_clk,
    output logic    o_pending
);

    localparam ce_cfg_t RESET_CFG = '{mode: MODE_INT, word: DEFAULT_WORD};

    logic [ACC_W-1:0]       r_acc;
    ce_cfg_t                r_live;
    ce_cfg_t                r_shadow;
    logic                   r_pending;
    logic                   r_en;
    logic                   r_clk;

    logic                   w_active;
    logic                   w_wrap;
    logic                   w_fire;
    logic                   w_apply;
    logic [CE_WORD_MAX_W:0] w_sum;

    always_comb begin
        w_active = i_rel_n & i_run;
        w_sum    = {1'b0, CE_WORD_MAX_W'(r_acc)} + {1'b0, r_live.word};
        if (r_live.mode == MODE_FRAC) begin
            w_wrap = w_sum[ACC_W];
        end else begin
            w_wrap = (CE_WORD_MAX_W'(r_acc) == r_live.word);
        end
        w_fire  = w_active & w_wrap;
        // An idle channel takes the shadow at once; a running one waits for its wrap.
        w_apply = r_pending & (~w_active | w_wrap);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc     <= '0;
            r_live    <= RESET_CFG;
            r_shadow  <= RESET_CFG;
            r_pending <= 1'b0;
            r_en      <= 1'b0;
            r_clk     <= 1'b0;
        end else begin
            r_en <= w_fire;

            if (!i_rel_n) begin
                r_clk <= 1'b0;
            end else if (w_fire) begin
                r_clk <= ~r_clk;
            end

            if (w_apply || !i_rel_n) begin
                r_acc <= '0;
            end else if (w_active) begin
                if (r_live.mode == MODE_FRAC) begin
                    r_acc <= ACC_W'(w_sum);
                end else if (w_wrap) begin
                    r_acc <= '0;
                end else begin
                    r_acc <= r_acc + ACC_W'(1);
                end
            end

            if (w_apply) begin
                r_live <= r_shadow;
            end

            if (i_cfg_we) begin
                r_shadow  <= i_cfg;
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_en      = r_en;
    assign o_clk     = r_clk;
    assign o_pending = r_pending;

endmodule

// File: rtl/clock_enable_gen.sv
// Multi-channel clock-enable generator: lock synchroniser, staged reset release
// and config decode around NUM_CH divider/accumulator channels.
module clock_enable_gen
    import clock_enable_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned ACC_W        = 16,
    parameter int unsigned DEFAULT_WORD = 27,
    parameter int unsigned RESET_DELAY  = 128,
    parameter int unsigned STAGE_GAP    = 16,
    parameter int unsigned SYNC_STAGES  = 3
) (
    input  logic              clk_cpu_fast,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic [NUM_CH-1:0] ch_run,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_ch,
    input  logic              cfg_mode,
    input  logic [ACC_W-1:0]  cfg_word,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] ch_clk,
    output logic [NUM_CH-1:0] rst_ch_n,
    output logic              locked_sync,
    output logic              all_released
);

    localparam int unsigned REL_SAT = rel_cnt_sat(RESET_DELAY, NUM_CH, STAGE_GAP);
    localparam int unsigned REL_W   = rel_cnt_width(REL_SAT);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [REL_W-1:0]       r_rel_cnt;
    logic [NUM_CH-1:0]      r_rst_ch_n;
    logic                   r_cfg_err;

    logic [NUM_CH-1:0]      w_rel_ok;
    logic [NUM_CH-1:0]      w_cfg_we;
    logic [NUM_CH-1:0]      w_pending;
    logic [7:0]             w_pending_pad;
    logic                   w_locked;
    logic                   w_cfg_oor;
    logic                   w_cfg_acc;
    ce_cfg_t                w_cfg;

    assign w_locked = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_rel_ok      = '0;
        w_cfg_we      = '0;
        w_pending_pad = '0;
        w_pending_pad[NUM_CH-1:0] = w_pending;

        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_rel_ok[k] = (32'(r_rel_cnt) >= (RESET_DELAY - 1 + k * STAGE_GAP));
        end

        w_cfg_oor = (32'(cfg_ch) >= NUM_CH);
        if (rst) begin
            cfg_ready = 1'b0;
        end else if (w_cfg_oor) begin
            cfg_ready = 1'b1;
        end else begin
            cfg_ready = ~w_pending_pad[cfg_ch];
        end
        w_cfg_acc = cfg_valid & cfg_ready;

        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_cfg_we[k] = w_cfg_acc & ~w_cfg_oor & (32'(cfg_ch) == k);
        end

        w_cfg = '{mode: cfg_mode, word: CE_WORD_MAX_W'(cfg_word)};
    end

    always_ff @(posedge clk_cpu_fast) begin
        if (rst) begin
            r_sync     <= '0;
            r_rel_cnt  <= '0;
            r_rst_ch_n <= '0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};

            if (!w_locked) begin
                r_rel_cnt <= '0;
            end else if (r_rel_cnt != REL_W'(REL_SAT)) begin
                r_rel_cnt <= r_rel_cnt + REL_W'(1);
            end

            // Gating with the lock drops every channel reset on the cycle after lock loss.
            r_rst_ch_n <= w_locked ? w_rel_ok : '0;
            r_cfg_err  <= w_cfg_acc & w_cfg_oor;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        ce_channel #(
            .ACC_W        (ACC_W),
            .DEFAULT_WORD (CE_WORD_MAX_W'(DEFAULT_WORD))
        ) u_ch (
            .i_clk     (clk_cpu_fast),
            .i_rst     (rst),
            .i_rel_n   (r_rst_ch_n[k]),
            .i_run     (ch_run[k]),
            .i_cfg_we  (w_cfg_we[k]),
            .i_cfg     (w_cfg),
            .o_en      (ch_en[k]),
            .o_clk     (ch_clk[k]),
            .o_pending (w_pending[k])
        );
    end

    assign rst_ch_n     = r_rst_ch_n;
    assign locked_sync  = w_locked;
    assign all_released = &r_rst_ch_n;
    assign cfg_err      = r_cfg_err;

endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed self-checking bench for clock_enable_gen with hand-computed cycle counts.
module tb_clock_enable_gen;
    import clock_enable_pkg::*;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned ACC_W  = 16;

    logic              clk_cpu_fast = 1'b0;
    logic              rst;
    logic              pll_locked;
    logic [NUM_CH-1:0] ch_run;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [2:0]        cfg_ch;
    logic              cfg_mode;
    logic [ACC_W-1:0]  cfg_word;
    logic              cfg_err;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] ch_clk;
    logic [NUM_CH-1:0] rst_ch_n;
    logic              locked_sync;
    logic              all_released;

    int errors = 0;
    int checks = 0;

    int n;
    int spur;
    int viol;
    int last0, bad0, per0, lastc, badc, last1, bad1, cnt2, cnt3;
    logic prev_clk0;

    always #5 clk_cpu_fast = ~clk_cpu_fast;

    clock_enable_gen dut (
        .clk_cpu_fast (clk_cpu_fast),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .ch_run       (ch_run),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_mode     (cfg_mode),
        .cfg_word     (cfg_word),
        .cfg_err      (cfg_err),
        .ch_en        (ch_en),
        .ch_clk       (ch_clk),
        .rst_ch_n     (rst_ch_n),
        .locked_sync  (locked_sync),
        .all_released (all_released)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_cpu_fast);
        #1;
    endtask

    task automatic wait_en(input int k, input int max, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!ch_en[k] && cnt < max);
        check("en_seen", 32'(ch_en[k]), 1);
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic mode, input logic [ACC_W-1:0] word);
        int waited = 0;
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_mode  = mode;
        cfg_word  = word;
        #1;
        while (!cfg_ready && waited < 50) begin
            tick();
            waited++;
        end
        check("cfg_accept_wait", 32'(waited >= 50), 0);
        tick();
        cfg_valid = 1'b0;
    endtask

    // Raise the lock right after an edge, then time sync and staged release against it.
    task automatic lock_seq(input string tag);
        int rise[NUM_CH];
        int ls_at  = -1;
        int first0 = -1;
        int sp     = 0;
        for (int k = 0; k < NUM_CH; k++) rise[k] = -1;
        pll_locked = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (locked_sync && ls_at < 0) ls_at = c;
            for (int k = 0; k < NUM_CH; k++) begin
                if (rst_ch_n[k] && rise[k] < 0) rise[k] = c;
            end
            if (ch_en[0] && first0 < 0) first0 = c;
            if (c <= 150 && ch_en != '0) sp++;
        end
        check({tag, "_locked_sync"}, ls_at, 3);
        for (int k = 0; k < NUM_CH; k++) begin
            check({tag, "_rst_ch_n_rise"}, rise[k], 131 + 16 * k);
        end
        check({tag, "_first_en0"}, first0, 159);
        check({tag, "_no_early_en"}, sp, 0);
        check({tag, "_all_released"}, 32'(all_released), 1);
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        ch_run     = '1;
        cfg_valid  = 1'b0;
        cfg_ch     = '0;
        cfg_mode   = MODE_INT;
        cfg_word   = '0;

        // Reset state
        repeat (3) tick();
        check("rst_ch_en", 32'(ch_en), 0);
        check("rst_ch_clk", 32'(ch_clk), 0);
        check("rst_rst_ch_n", 32'(rst_ch_n), 0);
        check("rst_locked_sync", 32'(locked_sync), 0);
        check("rst_all_released", 32'(all_released), 0);
        check("rst_cfg_ready", 32'(cfg_ready), 0);
        check("rst_cfg_err", 32'(cfg_err), 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(cfg_ready), 1);
        tick();

        // Config while channels are held in reset applies on the next cycle
        cfg_valid = 1'b1;
        cfg_ch    = 3'd1;
        cfg_mode  = MODE_INT;
        cfg_word  = 16'd9;
        #1;
        check("cfg_ready_idle", 32'(cfg_ready), 1);
        tick();
        cfg_valid = 1'b0;
        check("pending_blocks_ready", 32'(cfg_ready), 0);
        tick();
        check("inactive_apply", 32'(cfg_ready), 1);
        cfg_write(3'd2, MODE_FRAC, 16'h8000);
        cfg_write(3'd3, MODE_FRAC, 16'h4925);

        // Lock sequence
        lock_seq("lock1");

        // Default divider, ch_clk, fractional rates over one full accumulator cycle
        last0 = -1; bad0 = 0; per0 = 0; lastc = -1; badc = 0;
        last1 = -1; bad1 = 0; cnt2 = 0; cnt3 = 0;
        prev_clk0 = ch_clk[0];
        for (int c = 0; c < 65536; c++) begin
            tick();
            if (ch_en[0]) begin
                if (last0 >= 0) begin
                    per0++;
                    if (c - last0 != 28) bad0++;
                end
                last0 = c;
            end
            if (ch_en[1]) begin
                if (last1 >= 0 && c - last1 != 10) bad1++;
                last1 = c;
            end
            if (ch_clk[0] && !prev_clk0) begin
                if (lastc >= 0 && c - lastc != 56) badc++;
                lastc = c;
            end
            prev_clk0 = ch_clk[0];
            cnt2 += int'(ch_en[2]);
            cnt3 += int'(ch_en[3]);
        end
        check("div28_bad_periods", bad0, 0);
        check("div28_enough_periods", 32'(per0 >= 100), 1);
        check("ch_clk0_bad_periods", badc, 0);
        check("div10_bad_periods", bad1, 0);
        check("frac_8000_count", cnt2, 32768);
        check("frac_4925_count", cnt3, 18725);

        // Runtime update of ch1 from 9 to 4, accepted 4 cycles into a period
        wait_en(1, 20, n);
        repeat (3) tick();
        cfg_valid = 1'b1;
        cfg_ch    = 3'd1;
        cfg_mode  = MODE_INT;
        cfg_word  = 16'd4;
        #1;
        check("upd_ready_before", 32'(cfg_ready), 1);
        tick();
        cfg_valid = 1'b0;
        check("upd_ready_pending", 32'(cfg_ready), 0);
        n = 4;
        viol = 0;
        do begin
            tick();
            n++;
            if (!ch_en[1] && cfg_ready) viol++;
        end while (!ch_en[1] && n < 30);
        check("upd_old_period", n, 10);
        check("upd_ready_low", viol, 0);
        check("upd_ready_apply", 32'(cfg_ready), 1);
        wait_en(1, 20, n);
        check("upd_new_period1", n, 5);
        wait_en(1, 20, n);
        check("upd_new_period2", n, 5);

        // Out-of-range channel
        cfg_valid = 1'b1;
        cfg_ch    = 3'd6;
        cfg_word  = 16'd1;
        #1;
        check("oor_ready", 32'(cfg_ready), 1);
        tick();
        cfg_valid = 1'b0;
        check("oor_err_pulse", 32'(cfg_err), 1);
        tick();
        check("oor_err_once", 32'(cfg_err), 0);
        wait_en(1, 20, n);
        wait_en(1, 20, n);
        check("oor_ch1_unchanged", n, 5);
        wait_en(0, 40, n);
        wait_en(0, 40, n);
        check("oor_ch0_unchanged", n, 28);

        // Lock loss for 10 cycles, then relock
        pll_locked = 1'b0;
        spur = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 2) check("loss_sync_hold", 32'(locked_sync), 1);
            if (c == 3) check("loss_sync_fall", 32'(locked_sync), 0);
            if (c == 3) check("loss_rst_ch_n_hold", 32'(rst_ch_n), 32'hf);
            if (c == 4) check("loss_rst_ch_n_low", 32'(rst_ch_n), 0);
            if (c >= 5 && ch_en != '0) spur++;
        end
        check("loss_no_en", spur, 0);
        check("loss_ch_clk", 32'(ch_clk), 0);
        check("loss_all_released", 32'(all_released), 0);
        lock_seq("relock");

        // ch_run pause of 7 cycles stretches the period by 7
        wait_en(0, 40, n);
        repeat (5) tick();
        ch_run[0] = 1'b0;
        spur = 0;
        repeat (7) begin
            tick();
            if (ch_en[0]) spur++;
        end
        ch_run[0] = 1'b1;
        wait_en(0, 60, n);
        check("pause_period", 12 + n, 35);
        check("pause_no_en", spur, 0);

        // rst during staged release
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (140) tick();
        check("mid_release", 32'(rst_ch_n), 1);
        rst = 1'b1;
        tick();
        check("rst2_ch_en", 32'(ch_en), 0);
        check("rst2_ch_clk", 32'(ch_clk), 0);
        check("rst2_rst_ch_n", 32'(rst_ch_n), 0);
        check("rst2_locked_sync", 32'(locked_sync), 0);
        check("rst2_all_released", 32'(all_released), 0);
        check("rst2_cfg_ready", 32'(cfg_ready), 0);
        rst = 1'b0;
        tick();
        check("post_rst_no_en", 32'(ch_en), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
